// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction prefetch queue with sequential fetch, one outstanding request and redirect flush
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        pop,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   pend_pc;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          push;
  logic          do_pop;
  logic          has_room;

  // Only a live (non-stale) response in REQ is ever buffered.
  assign push     = mem_req & mem_ack & (state == REQ) & ~redirect;
  assign do_pop   = pop & out_valid & ~redirect;
  assign has_room = count_next < CNT_FULL;

  always_comb begin
    count_next = count;
    if (redirect)
      count_next = '0;
    else if (push && !do_pop)
      count_next = count + CNT_ONE;
    else if (!push && do_pop)
      count_next = count - CNT_ONE;
  end

  // Room is judged on the post-update count so a pop while full restarts fetch next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      fetch_pc <= RESET_PC;
      pend_pc  <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) begin
            fetch_pc <= redirect_pc;
            state    <= REQ;
            mem_req  <= 1'b1;
          end else if (has_room) begin
            state   <= REQ;
            mem_req <= 1'b1;
          end
        end
        REQ: begin
          if (mem_ack) begin
            if (redirect) begin
              fetch_pc <= redirect_pc;
            end else begin
              fetch_pc <= fetch_pc + PC_INC;
              if (!has_room) begin
                state   <= IDLE;
                mem_req <= 1'b0;
              end
            end
          end else if (redirect) begin
            pend_pc <= redirect_pc;
            state   <= DROP;
          end
        end
        DROP: begin
          // The bus still owns the stale address until its ack arrives.
          if (mem_ack) begin
            fetch_pc <= redirect ? redirect_pc : pend_pc;
            state    <= REQ;
          end else if (redirect) begin
            pend_pc <= redirect_pc;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else begin
      count <= count_next;
      if (redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          pc_mem[wr_ptr]    <= fetch_pc;
          instr_mem[wr_ptr] <= mem_rdata;
          wr_ptr            <= wr_ptr + AW'(1);
        end
        if (do_pop)
          rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  assign mem_addr  = fetch_pc;
  assign out_valid = (count != '0);
  assign out_instr = instr_mem[rd_ptr];
  assign out_pc    = pc_mem[rd_ptr];

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - directed and randomized checks of ifetch_queue against a queue-based reference model
module tb_ifetch_queue;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] PC_INC = 32'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        pop = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0), .PC_INC(PC_INC)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .pop(pop), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  logic [31:0] exp_addr = 32'h0;
  logic [31:0] stale_addr = 32'h0;
  bit          stale = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model view: a word list, the address the next live word must carry, and whether the bus request is stale.
  task automatic step(input bit a, input logic [31:0] d, input bit p, input bit r, input logic [31:0] rp);
    bit req_m;
    req_m = stale || (q.size() < DEPTH);
    check("out_valid", out_valid, 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("out_pc", out_pc, q[0].pc);
      check("out_instr", out_instr, q[0].instr);
    end
    check("mem_req", mem_req, 32'(req_m));
    if (req_m) check("mem_addr", mem_addr, stale ? stale_addr : exp_addr);
    mem_ack = a; mem_rdata = d; pop = p; redirect = r; redirect_pc = rp;
    if (r) begin
      q.delete();
      if (req_m && !a) begin
        if (!stale) stale_addr = exp_addr;
        stale = 1'b1;
      end else begin
        stale = 1'b0;
      end
      exp_addr = rp;
    end else begin
      if (p && q.size() != 0) void'(q.pop_front());
      if (req_m && a) begin
        if (stale) stale = 1'b0;
        else begin
          q.push_back('{pc: exp_addr, instr: d});
          exp_addr = exp_addr + PC_INC;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    mem_ack = 1'b0; pop = 1'b0; redirect = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    check("rst_mem_req", mem_req, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_out_valid", out_valid, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    rst_n = 1'b1;
    #1 check("rel_mem_req", mem_req, 32'h0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("first_req", mem_req, 32'h1);
    check("first_addr", mem_addr, 32'h0);

    // zero-wait fill
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'hD000_0000 + 32'(i), 1'b0, 1'b0, '0);
    check("full_req", mem_req, 32'h0);
    check("full_head_pc", out_pc, 32'h0);
    check("full_head_instr", out_instr, 32'hD000_0000);

    step(1'b0, '0, 1'b1, 1'b0, '0);
    check("pop_full_pc", out_pc, 32'h4);
    check("pop_full_req", mem_req, 32'h1);
    check("pop_full_addr", mem_addr, 32'h10);

    // stale discard
    step(1'b0, '0, 1'b0, 1'b1, 32'h100);
    step(1'b0, '0, 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b0, 1'b0, '0);
    step(1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, '0);
    check("stale_valid", out_valid, 32'h0);
    check("stale_addr", mem_addr, 32'h100);
    step(1'b1, 32'h1111_0100, 1'b0, 1'b0, '0);
    check("stale_first_pc", out_pc, 32'h100);

    // redirect + ack + pop on non-empty queue
    step(1'b1, 32'hBAD1_BAD1, 1'b1, 1'b1, 32'h200);
    check("redir_valid", out_valid, 32'h0);
    check("redir_addr", mem_addr, 32'h200);

    // address wrap then pointer wrap
    step(1'b1, 32'hBAD2_BAD2, 1'b0, 1'b1, 32'hFFFF_FFF8);
    check("wrap_addr0", mem_addr, 32'hFFFF_FFF8);
    step(1'b1, 32'hEEEE_0000, 1'b0, 1'b0, '0);
    step(1'b1, 32'hEEEE_0001, 1'b0, 1'b0, '0);
    check("wrap_addr2", mem_addr, 32'h0);
    step(1'b1, 32'hEEEE_0002, 1'b0, 1'b0, '0);
    check("wrap_head", out_pc, 32'hFFFF_FFF8);
    for (int i = 0; i < 10; i++) step(1'b1, $urandom(), 1'b1, 1'b0, '0);

    for (int i = 0; i < 3000; i++)
      step(($urandom() % 2) == 0, $urandom(), ($urandom() % 2) == 0,
           ($urandom() % 20) == 0, ($urandom() % 4 == 0) ? 32'hFFFF_FFF0 : {$urandom()} & ~32'h3);

    // reset mid-transaction, late ack ignored
    while (!mem_req) step(1'b0, '0, 1'b1, 1'b0, '0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", mem_req, 32'h0);
    check("mid_rst_addr", mem_addr, 32'h0);
    check("mid_rst_valid", out_valid, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    mem_ack = 1'b0;
    check("late_ack_valid", out_valid, 32'h0);
    check("late_ack_req", mem_req, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction prefetch queue between the instruction memory and the core's decode path. Sequential fetch addresses are generated internally, one outstanding request is issued over a req/ack memory handshake, and returned words are buffered with their PCs in a small FIFO. The core reads the queue head, pops consumed entries, and redirects the fetch stream on a PC change. A redirect flushes the queue and discards any in-flight stale response.

## Interface
- DEPTH, 4, queue entries (power of 2, ≥2)
- RESET_PC, 32'h0, first fetch address after reset
- PC_INC, 4, fetch address increment per word
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- mem_req  out  1  fetch request, held until mem_ack
- mem_addr  out  32  fetch address, stable while mem_req=1
- mem_ack  in  1  response strobe; mem_rdata valid this cycle
- mem_rdata  in  32  fetched instruction word
- out_valid  out  1  queue head valid (count≠0)
- out_instr  out  32  head instruction
- out_pc  out  32  head instruction address
- pop  in  1  consume head; ignored when out_valid=0
- redirect  in  1  flush queue, restart fetch at redirect_pc
- redirect_pc  in  32  new fetch address

## Operation
- Storage: DEPTH×{pc, instr}, read/write pointers of log2(DEPTH) bits wrapping modulo DEPTH, count of log2(DEPTH)+1 bits.
- fetch_pc register drives mem_addr; +PC_INC on each accepted ack, modulo 2^32.
- mem_ack is ignored when mem_req=0.
- FSM states:
  - IDLE: mem_req=0.
    - redirect → REQ, fetch_pc←redirect_pc.
    - Otherwise, if count<DEPTH → REQ.
  - REQ: mem_req=1.
    - ack without redirect: push {fetch_pc, mem_rdata}, fetch_pc+=PC_INC. Stay REQ if post-update count<DEPTH, else IDLE.
    - ack with redirect: data discarded, fetch_pc←redirect_pc, stay REQ.
    - redirect without ack → DROP, fetch_pc held for the bus; the new address is latched in pend_pc.
  - DROP: mem_req=1, mem_addr = stale address.
    - ack: data discarded, fetch_pc←pend_pc → REQ.
    - A further redirect updates pend_pc. With ack, the newest redirect_pc is used.
- Redirect: count←0 and pointers←0 next cycle; a same-cycle pop is ignored; no push that cycle.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full: never requested while full. Pop while full frees space; REQ is entered the next cycle.
- out_instr/out_pc are read from the storage at rd_ptr. Their value is don't-care when out_valid=0.

## Timing
- Reset values: mem_req=0, mem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0, state IDLE, count=0, pointers=0.
- First request: mem_req=1 in the second cycle after rst_n rises (IDLE→REQ).
- Zero-wait memory (ack in the same cycle as req): one word per cycle, back-to-back, until full.
- Ack at cycle T → out_valid=1 at T+1 (if the queue was empty).
- Redirect at T from IDLE, or from REQ with ack → mem_req=1, mem_addr=redirect_pc at T+1.
- Redirect at T from REQ without ack → DROP. The new address appears on the cycle after the stale ack.
- Pop at T → head advances at T+1.
- Reset asserted mid-transaction: immediate return to reset values. A late mem_ack after reset is ignored, since mem_req=0.

## Test plan
- Reset check: outputs at reset values; after release, mem_req=1 with mem_addr=0x0 at the second clock.
- Zero-wait fill, DEPTH=4, no pop: addresses 0x0, 0x4, 0x8, 0xC accepted on consecutive cycles → count=4, mem_req drops. Head is pc=0x0 with data D0.
- Pop when full: single pop → out_pc=0x4; next cycle mem_req=1 with mem_addr=0x10.
- Stale discard: ack delayed 3 cycles, redirect to 0x100 while waiting. The stale word is not pushed, then mem_req issues with mem_addr=0x100. The first out_pc=0x100.
- Redirect with same-cycle ack and pop on a non-empty queue: queue empties next cycle, the acked word is absent, and mem_addr=redirect_pc the next cycle.
- Wrap-around: redirect to 0xFFFFFFF8 → fetches 0xFFFFFFF8, 0xFFFFFFFC, 0x0. Pointer wrap is verified by 10 push/pop cycles with in-order data.
